parallel_accumulator: RTL and testbench



---
 rtl/parallel_accumulator_pkg.sv | 23 ++
 rtl/parallel_accumulator_lane.sv | 45 ++++
 rtl/parallel_accumulator.sv | 116 +++++++++++
 tb/tb_parallel_accumulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/parallel_accumulator_pkg.sv
// Shared types and default sizing for the parallel accumulator.
// Optional overflow tracking is enabled with PARALLEL_ACCUMULATOR_OVERFLOW_EN.
package parallel_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DATA_W    = 32;
  localparam int NUM_LOADS = 1024;
  localparam int N_LANES   = 4;

  // Lane select needs at least one bit even when there is a single lane
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = $clog2(NUM_LOADS + 1);
  localparam int SEL_W = sel_width(N_LANES);

endpackage

// File: rtl/parallel_accumulator_lane.sv
// One partial-sum lane: adds the incoming word into its register when enabled.
// With PARALLEL_ACCUMULATOR_OVERFLOW_EN a sticky carry flag is also kept.
module accumulator_lane #(
  parameter int DATA_W = parallel_accumulator_pkg::DATA_W
) (
  input  logic              bus_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
  ,
  output logic              carry
`endif
);

`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
  logic [DATA_W:0] sum_wide;

  assign sum_wide = {1'b0, sum} + {1'b0, data};

  // Accumulate with wraparound and remember whether any add carried out
  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      sum   <= '0;
      carry <= 1'b0;
    end else if (enable) begin
      sum <= sum_wide[DATA_W-1:0];
      if (sum_wide[DATA_W]) begin
        carry <= 1'b1;
      end
    end
  end
`else
  // Accumulate with wraparound modulo 2^DATA_W
  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum + data;
    end
  end
`endif

endmodule

// File: rtl/parallel_accumulator.sv
// Streaming summation engine: words are spread round-robin over N_LANES lanes,
// then the lanes are folded one per cycle into a single held result.
// Optional sticky overflow output is enabled with PARALLEL_ACCUMULATOR_OVERFLOW_EN.
module parallel_accumulator #(
  parameter int DATA_W    = parallel_accumulator_pkg::DATA_W,
  parameter int NUM_LOADS = parallel_accumulator_pkg::NUM_LOADS,
  parameter int N_LANES   = parallel_accumulator_pkg::N_LANES
) (
  input  logic              bus_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] load,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  import parallel_accumulator_pkg::*;

  // Widths derived from this instance's parameters rather than the package defaults
  localparam int CNT_BITS = $clog2(NUM_LOADS + 1);
  localparam int SEL_BITS = sel_width(N_LANES);

  state_t                           state;
  logic [CNT_BITS-1:0]              count;
  logic [SEL_BITS-1:0]              sel;
  logic [SEL_BITS-1:0]              red_idx;
  logic [DATA_W-1:0]                acc;
  logic [DATA_W-1:0]                red_sum;
  logic [N_LANES-1:0]               lane_en;
  logic [N_LANES-1:0][DATA_W-1:0]   lane_sum;

`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
  logic [N_LANES-1:0] lane_carry;
  logic [DATA_W:0]    red_wide;
  logic               red_ovf;

  assign red_wide = {1'b0, acc} + {1'b0, lane_sum[red_idx]};
  assign red_sum  = red_wide[DATA_W-1:0];
  assign overflow = red_ovf | (|lane_carry);
`else
  assign red_sum = acc + lane_sum[red_idx];
`endif

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign lane_en[i] = (state == ACCUM) && (sel == SEL_BITS'(i));

    accumulator_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .bus_clk (bus_clk),
      .reset_n (reset_n),
      .enable  (lane_en[i]),
      .data    (load),
      .sum     (lane_sum[i])
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
      ,
      .carry   (lane_carry[i])
`endif
    );
  end

  // Sequencer: count captured words, fold the lanes one per cycle, then hold the total
  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACCUM;
      count        <= '0;
      sel          <= '0;
      red_idx      <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
      red_ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          count <= count + CNT_BITS'(1);
          if (sel == SEL_BITS'(N_LANES - 1)) begin
            sel <= '0;
          end else begin
            sel <= sel + SEL_BITS'(1);
          end
          if (count == CNT_BITS'(NUM_LOADS - 1)) begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
          if (red_wide[DATA_W]) begin
            red_ovf <= 1'b1;
          end
`endif
          if (red_idx == SEL_BITS'(N_LANES - 1)) begin
            result       <= red_sum;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            acc     <= red_sum;
            red_idx <= red_idx + SEL_BITS'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_accumulator.sv
// Self-checking bench for parallel_accumulator with a sum-of-words reference model.
// Overflow checks are included when PARALLEL_ACCUMULATOR_OVERFLOW_EN is defined.
module tb_parallel_accumulator;

  localparam int NWORDS = 1024;
  localparam int LANES  = 4;

  logic        bus_clk;
  logic        reset_n;
  logic [31:0] load;
  logic [31:0] result;
  logic        result_valid;
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
  logic        overflow;
`endif

  int compared;
  int mismatched;

  logic [31:0] words[$];

  parallel_accumulator #(
    .DATA_W    (32),
    .NUM_LOADS (NWORDS),
    .N_LANES   (LANES)
  ) dut (
    .bus_clk      (bus_clk),
    .reset_n      (reset_n),
    .load         (load),
    .result       (result),
    .result_valid (result_valid)
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
    ,
    .overflow     (overflow)
`endif
  );

  // Free-running clock, 10 time units per period
  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  // Compare one observed value against its expectation and tally the outcome
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference total of every captured word, wrapped to 32 bits
  function automatic logic [31:0] modelSum();
    logic [63:0] total = 64'd0;
    foreach (words[i]) total += {32'd0, words[i]};
    return total[31:0];
  endfunction

  // Overflow is set exactly when the unbounded total no longer fits in 32 bits
  function automatic logic modelOverflow();
    logic [63:0] total = 64'd0;
    foreach (words[i]) total += {32'd0, words[i]};
    return (total[63:32] != 32'd0);
  endfunction

  // Assert reset off the clock edge, confirm outputs clear at once, release on a falling edge
  task automatic doReset(input string tag);
    @(negedge bus_clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
    checkOutput({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
`endif
    @(negedge bus_clk);
    reset_n = 1'b1;
    words.delete();
  endtask

  // Drive n words, one per cycle; mode 0 constant k, 1 ramp, 2 random 16-bit, 3 random 32-bit
  task automatic applyStimulus(input int mode, input logic [31:0] k, input int n);
    for (int w = 0; w < n; w++) begin
      case (mode)
        0:       load = k;
        1:       load = w;
        2:       load = $urandom_range(0, 65535);
        default: load = $urandom;
      endcase
      words.push_back(load);
      @(negedge bus_clk);
      if ((w % 256) == 128) begin
        checkOutput("accum_result_zero", result, 32'd0);
        checkOutput("accum_valid_low", {31'd0, result_valid}, 32'd0);
      end
    end
    load = $urandom;
  endtask

  // Wait (bounded) for the total, checking latency, zero result during reduction and the sum
  task automatic waitResult(input string tag, input logic [31:0] expected);
    int c = 0;
    while (c < 20) begin
      @(posedge bus_clk);
      #1;
      c++;
      load = $urandom;
      if (result_valid) break;
      checkOutput({tag, "_reduce_zero"}, result, 32'd0);
    end
    checkOutput({tag, "_latency"}, c, LANES);
    checkOutput({tag, "_sum"}, result, expected);
`ifdef PARALLEL_ACCUMULATOR_OVERFLOW_EN
    checkOutput({tag, "_ovf"}, {31'd0, overflow}, {31'd0, modelOverflow()});
`endif
  endtask

  // Keep clocking with changing input and require the finished total to stay put
  task automatic holdCheck(input int cycles, input logic [31:0] expected);
    for (int i = 0; i < cycles; i++) begin
      @(negedge bus_clk);
      load = $urandom;
      checkOutput("hold_result", result, expected);
      checkOutput("hold_valid", {31'd0, result_valid}, 32'd1);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    load       = 32'd0;
    reset_n    = 1'b1;
    #1;
    reset_n = 1'b0;
    #2;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_valid", {31'd0, result_valid}, 32'd0);
    @(negedge bus_clk);
    reset_n = 1'b1;

    $display("[TB] constant stream of ones");
    applyStimulus(0, 32'd1, NWORDS);
    waitResult("const1", 32'h400);

    doReset("rst_done1");
    $display("[TB] ramp stream");
    applyStimulus(1, 32'd0, NWORDS);
    waitResult("ramp", 32'h7FE00);

    doReset("rst_done2");
    $display("[TB] random 16-bit stream");
    applyStimulus(2, 32'd0, NWORDS);
    waitResult("rand16", modelSum());
    holdCheck(100, modelSum());

    doReset("rst_done3");
    $display("[TB] all-ones wrap stream");
    applyStimulus(0, 32'hFFFF_FFFF, NWORDS);
    waitResult("wrap", 32'hFFFF_FC00);

    doReset("rst_done4");
    $display("[TB] random 32-bit stream");
    applyStimulus(3, 32'd0, NWORDS);
    waitResult("rand32", modelSum());

    doReset("rst_done5");
    $display("[TB] reset after 500 words then stream of twos");
    applyStimulus(3, 32'd0, 500);
    doReset("rst_mid");
    applyStimulus(0, 32'd2, NWORDS);
    waitResult("twos", 32'd2048);

    doReset("rst_done6");
    $display("[TB] reset during reduction then all-zero stream");
    applyStimulus(0, 32'd3, NWORDS);
    @(posedge bus_clk);
    @(posedge bus_clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_reduce_result", result, 32'd0);
    checkOutput("rst_reduce_valid", {31'd0, result_valid}, 32'd0);
    @(negedge bus_clk);
    reset_n = 1'b1;
    words.delete();
    applyStimulus(0, 32'd0, NWORDS);
    waitResult("zeros", 32'd0);
    checkOutput("zeros_valid", {31'd0, result_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
